// File: rtl/ex_arbiter.sv
// -----------------------------------------------------------------------------
// ex_arbiter
//
// Shares a single execution_block between two requesters: port 0 (main decode
// pipeline) and port 1 (secondary requester, e.g. debug or micro-sequencer).
// One operation is chosen per cycle by round-robin priority. A requester may
// lock the grant for back-to-back sequences, bounded by MAX_LOCK. Issued
// operands are registered toward the execution_block. A tag pipe follows each
// operation through the fixed block latency and routes the result back to the
// port that issued it.
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   reqN_valid/lock          request present / keep grant next cycle (N=0,1)
//   reqN_a/b/din/op          operands, data_in and opcode for port N
//   reqN_ready               combinational accept for port N
//   ex_a/ex_b/ex_din/ex_op   registered drive into execution_block
//   ex_ans/ex_flag           execution_block result, valid EX_LAT after issue
//   rsp0_valid/rsp1_valid    one-cycle result strobe per port
//   rsp_ans/rsp_flag         registered result, held between strobes
//   busy                     at least one operation in flight
// -----------------------------------------------------------------------------
module ex_arbiter #(
    parameter int unsigned EX_LAT   = 1,
    parameter logic [5:0]  NOP_OP   = 6'd63,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic        req0_lock,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req0_din,
    input  logic [5:0]  req0_op,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic        req1_lock,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [15:0] req1_din,
    input  logic [5:0]  req1_op,
    output logic        req1_ready,

    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [15:0] ex_din,
    output logic [5:0]  ex_op,
    input  logic [15:0] ex_ans,
    input  logic [1:0]  ex_flag,

    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_ans,
    output logic [1:0]  rsp_flag,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    typedef struct packed {
        logic        valid;
        logic        lock;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] din;
        logic [5:0]  op;
    } req_t;

    // Lock owner state: free, or held by one of the two ports.
    typedef enum logic [1:0] {
        LK_FREE  = 2'd0,
        LK_PORT0 = 2'd1,
        LK_PORT1 = 2'd2
    } lock_st_e;

    req_t [1:0]       w_req;

    lock_st_e         r_lk_state;
    lock_st_e         w_lk_state_nx;
    logic [CNT_W-1:0] r_lk_cnt;
    logic [CNT_W-1:0] w_lk_cnt_nx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_rr;
    logic             w_rr_nx;

    logic             w_own_v;
    logic             w_own;
    logic             w_cont;
    logic             w_gnt_v;
    logic             w_gnt_p;

    logic [15:0]      r_ex_a;
    logic [15:0]      r_ex_b;
    logic [15:0]      r_ex_din;
    logic [5:0]       r_ex_op;
    logic [15:0]      r_rsp_ans;
    logic [1:0]       r_rsp_flag;

    // Stage i holds the operation issued i edges ago; the last stage is the
    // response strobe itself, so busy also covers the strobe cycle.
    logic [EX_LAT:0]  r_vld_pipe;
    logic [EX_LAT:0]  r_tag_pipe;

    assign w_req[0] = {req0_valid, req0_lock, req0_a, req0_b, req0_din, req0_op};
    assign w_req[1] = {req1_valid, req1_lock, req1_a, req1_b, req1_din, req1_op};

    assign w_own_v = (r_lk_state != LK_FREE);
    assign w_own   = (r_lk_state == LK_PORT1);

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_v = 1'b0;
        w_gnt_p = 1'b0;
        if (!reset) begin
            if (w_own_v) begin
                // Owner keeps the grant while it has work; otherwise the
                // other port may use the idle slot.
                if (w_req[w_own].valid) begin
                    w_gnt_v = 1'b1;
                    w_gnt_p = w_own;
                end else if (w_req[~w_own].valid) begin
                    w_gnt_v = 1'b1;
                    w_gnt_p = ~w_own;
                end
            end else if (w_req[0].valid && w_req[1].valid) begin
                w_gnt_v = 1'b1;
                w_gnt_p = r_rr;
            end else if (w_req[0].valid) begin
                w_gnt_v = 1'b1;
                w_gnt_p = 1'b0;
            end else if (w_req[1].valid) begin
                w_gnt_v = 1'b1;
                w_gnt_p = 1'b1;
            end
        end
    end

    assign req0_ready = w_gnt_v & ~w_gnt_p;
    assign req1_ready = w_gnt_v &  w_gnt_p;

    // ------------------------------------------------------------------
    // Lock / round-robin next state
    // ------------------------------------------------------------------
    always_comb begin
        w_lk_state_nx = r_lk_state;
        w_lk_cnt_nx   = r_lk_cnt;
        w_rr_nx       = r_rr;
        // Owner continuing its locked run: the pointer is left alone and the
        // run length keeps counting.
        w_cont        = w_own_v && w_gnt_v && (w_gnt_p == w_own);
        w_cnt_inc     = (w_cont ? r_lk_cnt : '0) + CNT_W'(1);

        if (!w_gnt_v) begin
            // No issue implies the owner (if any) had nothing to send.
            w_lk_state_nx = LK_FREE;
            w_lk_cnt_nx   = '0;
        end else begin
            if (!w_cont) begin
                w_rr_nx = ~w_gnt_p;
            end
            if (!w_req[w_gnt_p].lock) begin
                w_lk_state_nx = LK_FREE;
                w_lk_cnt_nx   = '0;
            end else if (w_cnt_inc >= CNT_W'(MAX_LOCK)) begin
                // Run limit hit: release and hand priority to the other port.
                w_lk_state_nx = LK_FREE;
                w_lk_cnt_nx   = '0;
                w_rr_nx       = ~w_gnt_p;
            end else begin
                w_lk_state_nx = w_gnt_p ? LK_PORT1 : LK_PORT0;
                w_lk_cnt_nx   = w_cnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, issue and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lk_state <= LK_FREE;
            r_lk_cnt   <= '0;
            r_rr       <= 1'b0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_din   <= '0;
            r_ex_op    <= NOP_OP;
            r_rsp_ans  <= '0;
            r_rsp_flag <= '0;
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
        end else begin
            r_lk_state <= w_lk_state_nx;
            r_lk_cnt   <= w_lk_cnt_nx;
            r_rr       <= w_rr_nx;

            if (w_gnt_v) begin
                r_ex_a   <= w_req[w_gnt_p].a;
                r_ex_b   <= w_req[w_gnt_p].b;
                r_ex_din <= w_req[w_gnt_p].din;
                r_ex_op  <= w_req[w_gnt_p].op;
            end else begin
                // Operands hold so the block inputs stay quiet while idle.
                r_ex_op  <= NOP_OP;
            end

            r_vld_pipe <= {r_vld_pipe[EX_LAT-1:0], w_gnt_v};
            r_tag_pipe <= {r_tag_pipe[EX_LAT-1:0], w_gnt_p};

            // The tag about to enter the strobe stage marks the edge where the
            // block output belongs to that operation.
            if (r_vld_pipe[EX_LAT-1]) begin
                r_rsp_ans  <= ex_ans;
                r_rsp_flag <= ex_flag;
            end
        end
    end

    assign ex_a       = r_ex_a;
    assign ex_b       = r_ex_b;
    assign ex_din     = r_ex_din;
    assign ex_op      = r_ex_op;
    assign rsp_ans    = r_rsp_ans;
    assign rsp_flag   = r_rsp_flag;
    assign rsp0_valid = r_vld_pipe[EX_LAT] & ~r_tag_pipe[EX_LAT];
    assign rsp1_valid = r_vld_pipe[EX_LAT] &  r_tag_pipe[EX_LAT];
    assign busy       = |r_vld_pipe;

endmodule

// File: doc/ex_arbiter.md
Name: ex_arbiter

Overview:
Two-requester arbiter and issue sequencer that shares the single execution_block between the main decode pipeline (port 0) and a secondary requester such as a debug/test or multi-cycle micro-sequencer (port 1). It selects one operation per cycle using round-robin priority, with a bounded lock for back-to-back sequences. It drives A/B/data_in/op_dec into execution_block, tracks in-flight operations through the block's fixed latency, and routes ans_ex/flag_ex back to the requester that issued them. When no operation is issued, it drives a NOP opcode.

Parameters:
EX_LAT, 1, execution_block latency in cycles from op_dec/operands registered to ans_ex/flag_ex valid (range 1..4)
NOP_OP, 6'd63, opcode driven on ex_op when no issue occurs
MAX_LOCK, 4, maximum consecutive grants to a locking requester before forced rotation (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 has an operation
req0_lock  in  1  port 0 requests to keep the grant next cycle
req0_a, req0_b, req0_din  in  16 each  port 0 operands and data_in
req0_op  in  6  port 0 opcode
req0_ready  out  1  port 0 operation accepted this cycle (combinational)
req1_valid, req1_lock, req1_a, req1_b, req1_din, req1_op, req1_ready  same as port 0, for port 1
ex_a, ex_b, ex_din  out  16 each  registered operands to execution_block A, B, data_in
ex_op  out  6  registered opcode to execution_block op_dec
ex_ans  in  16  execution_block ans_ex
ex_flag  in  2  execution_block flag_ex
rsp0_valid, rsp1_valid  out  1 each  one-cycle result strobe per port
rsp_ans  out  16  registered result
rsp_flag  out  2  registered flags
busy  out  1  at least one operation in flight

Behaviour:
- Reset (synchronous, sampled at a clk edge with reset=1): ex_a=ex_b=ex_din=0; ex_op=NOP_OP; rsp0_valid=rsp1_valid=0; rsp_ans=0; rsp_flag=0; in-flight tag pipe cleared; rr pointer=0 (port 0 has priority); lock owner cleared; lock count=0; busy=0. Reset during operation discards in-flight operations, and no rsp strobe follows.
- Grant (combinational; at most one readyN high; readyN=0 during reset):
  - Locked state (lock owner L valid): grant L if reqL_valid, else grant the other port if valid.
  - Unlocked state: if both ports are valid, grant the port at the rr pointer; if one port is valid, grant it.
- Issue at edge with reqN_valid&&reqN_ready: ex_* <= reqN operands/opcode; tag {1,N} enters the tag pipe. Without an issue: ex_op <= NOP_OP; ex_a/ex_b/ex_din hold; a tag with valid=0 enters.
- Round-robin pointer: after an unlocked grant to N, the pointer moves to the other port.
- Lock rules:
  - Issue by N with reqN_lock=1 makes N the lock owner and increments the lock count.
  - The lock clears when the owner issues with lock=0, when the owner is not valid in a cycle, or when the lock count reaches MAX_LOCK.
  - When MAX_LOCK is reached: the pointer moves to the other port, that port gets priority next cycle, and the lock count resets to 0.
  - Any cycle the non-owner is granted also clears the lock.
- Tag pipe: EX_LAT+1 stages. At the edge where the tag exits (EX_LAT edges after issue), sample ex_ans/ex_flag into rsp_ans/rsp_flag and set rspN_valid for exactly one cycle.
- Latency and throughput:
  - Issue edge k -> ex_* visible after k -> result sampled at edge k+EX_LAT -> rspN_valid high in cycle after edge k+EX_LAT.
  - Full throughput: one issue per cycle, responses in issue order, no response backpressure.
- Response outputs: rsp_ans/rsp_flag hold their last value when no rsp strobe is active.
- busy = OR of tag-pipe valid bits.
- Simultaneous events:
  - Both ports valid with equal priority: follow the pointer.
  - Owner drops lock while the other port is valid: the other port wins the next cycle.
  - Issue and response in the same cycle are independent.

Test Plan:
- Reset then idle: after reset, ex_op=63, both readys=0 while both valids=0, busy=0, no rsp strobes for 10 cycles.
- Single issue: req0 a=16'h4000, b=16'hC000, op=1, din=16'h0008 for one cycle. Required: req0_ready=1; ex_a=4000, ex_b=C000, ex_op=1 after that edge; rsp0_valid for exactly 1 cycle, EX_LAT+1 cycles after issue, with rsp_ans/rsp_flag equal to execution_block output; rsp1_valid stays 0.
- Contention, no lock: both ports valid for 6 cycles with port 0 op=1 and port 1 op=28. Required: grants alternate 0,1,0,1,0,1; responses return in the same order to the matching rsp strobes.
- Lock limit with MAX_LOCK=4: req1 valid with lock held for 8 cycles, req0 valid throughout, both starting unlocked with pointer=1. Required: port1 granted 4 consecutive cycles, then port 0 granted once, then port 1 resumes.
- Reset mid-flight: issue 3 back-to-back ops from port 0, then assert reset for 1 cycle at the edge after the third issue. Required: no rsp strobes afterward, busy=0, ex_op=63.
- Idle gap: port 0 issues op=29, then valid=0 for 3 cycles. Required: ex_op=63 during the gap; ex_a/ex_b hold 4000/C000; one rsp0 strobe only.
